// File: rtl/pong_score_keeper_pkg.sv
// Shared definitions for the pong score keeper.
//   - match state encoding (IDLE/PLAY/HOLD/OVER)
//   - player IDs (P1/P2)
//   - active-low 7-segment lookup for hex digits plus the blank code
//   - small BCD helpers used by the score counters and win check
package pong_score_keeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Two-digit BCD increment, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Elaboration-time conversion of a 0..99 integer to BCD.
    function automatic logic [7:0] bin2bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment scanner.
//   clk, rst      : system clock, asynchronous active-low reset
//   i_score1/2    : BCD scores {tens,ones} for player 1 / player 2
//   o_an          : digit enables, active-low; [3]=p1 tens .. [0]=p2 ones
//   o_seg         : segments {g,f,e,d,c,b,a}, active-low
// A prescaler counts 0..SCAN_DIV-1; on each wrap the digit index steps
// 3->2->1->0->3 and an/seg are loaded together so no ghost cycle appears.
// Zero tens digits are blanked.
module seg7_scan
    import pong_score_keeper_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_score1,
    input  logic [7:0] i_score2,
    output logic [3:0] o_an,
    output logic [6:0] o_seg
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_wrap;
    logic [1:0]    w_idx_next;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg_next;

    assign w_wrap     = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_next = r_idx - 2'd1;

    // Digit and segment pattern for the index that becomes active on wrap.
    always_comb begin
        w_digit = 4'h0;
        w_blank = 1'b0;
        case (w_idx_next)
            2'd3: begin
                w_digit = i_score1[7:4];
                w_blank = (i_score1[7:4] == 4'h0);
            end
            2'd2: w_digit = i_score1[3:0];
            2'd1: begin
                w_digit = i_score2[7:4];
                w_blank = (i_score2[7:4] == 4'h0);
            end
            default: w_digit = i_score2[3:0];
        endcase
        w_seg_next = w_blank ? SEG_BLANK : seg_decode(w_digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_an    <= 4'b1111;
            r_seg   <= SEG_BLANK;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= w_idx_next;
            r_an    <= ~(4'b0001 << w_idx_next);
            r_seg   <= w_seg_next;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: match FSM, BCD scores and 7-segment display drive.
//   clk, rst        : system clock, asynchronous active-low reset
//   start           : level request to begin/restart a match (asynchronous)
//   lose1, lose2    : player 1 / player 2 missed (asynchronous level flags)
//   score1, score2  : BCD scores {tens,ones}
//   playing         : high in PLAY and HOLD
//   game_over       : high in OVER
//   winner          : 0 = player 1, 1 = player 2; valid while game_over
//   an, seg         : multiplexed display, both active-low
// Build option: define PONG_DEUCE_EN to require a 2-point lead to win
// (scores then continue past WIN_SCORE, saturating at 99).
// Each input goes through a 2-flop synchroniser and a registered rising-edge
// detector, so an event pulse appears 3 cycles after the input rises and the
// score register updates one cycle later.
module pong_score_keeper
    import pong_score_keeper_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter int unsigned SCAN_DIV    = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lose1,
    input  logic       lose2,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic       playing,
    output logic       game_over,
    output logic       winner,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [7:0]  WIN_BCD   = bin2bcd(WIN_SCORE);
    localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    localparam int unsigned EV_L1 = 0;
    localparam int unsigned EV_L2 = 1;
    localparam int unsigned EV_ST = 2;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [2:0] w_async_in;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_sync3;
    logic [2:0] r_ev;

    assign w_async_in = {start, lose2, lose1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_ev    <= '0;
        end else begin
            r_sync1 <= w_async_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_ev    <= r_sync2 & ~r_sync3;
        end
    end

    logic w_l1_ev;
    logic w_l2_ev;
    logic w_start_ev;

    assign w_l1_ev    = r_ev[EV_L1];
    assign w_l2_ev    = r_ev[EV_L2];
    assign w_start_ev = r_ev[EV_ST];

    // ------------------------------------------------------------------
    // Score arithmetic and win detection
    // ------------------------------------------------------------------
    state_e        r_state;
    logic [7:0]    r_score1;
    logic [7:0]    r_score2;
    logic          r_playing;
    logic          r_game_over;
    logic          r_winner;
    logic [HW-1:0] r_hold_cnt;

    logic [7:0] w_inc1;
    logic [7:0] w_inc2;
    logic       w_p1_wins;
    logic       w_p2_wins;

    assign w_inc1 = bcd_inc(r_score1);
    assign w_inc2 = bcd_inc(r_score2);

`ifdef PONG_DEUCE_EN
    // Win needs score >= WIN_SCORE with a 2-point lead. At a 99-99 tie the
    // scorer whose point just reached 99 takes the match.
    function automatic logic deuce_win(input logic [7:0] new_s, input logic [7:0] old_s,
                                       input logic [7:0] other);
        logic [7:0] n_bin;
        logic [7:0] o_bin;
        n_bin = bcd2bin(new_s);
        o_bin = bcd2bin(other);
        return (new_s >= WIN_BCD) &&
               ((n_bin >= o_bin + 8'd2) ||
                (old_s != 8'h99 && new_s == 8'h99 && other == 8'h99));
    endfunction

    assign w_p1_wins = deuce_win(w_inc1, r_score1, r_score2);
    assign w_p2_wins = deuce_win(w_inc2, r_score2, r_score1);
`else
    assign w_p1_wins = (w_inc1 == WIN_BCD);
    assign w_p2_wins = (w_inc2 == WIN_BCD);
`endif

    // ------------------------------------------------------------------
    // Match FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_score1    <= 8'h00;
            r_score2    <= 8'h00;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= P1;
            r_hold_cnt  <= '0;
        end else if (w_start_ev) begin
            // A start event restarts the match from any state.
            r_state     <= PLAY;
            r_score1    <= 8'h00;
            r_score2    <= 8'h00;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
            r_winner    <= P1;
            r_hold_cnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: ;
                PLAY: begin
                    if (w_l1_ev && w_l2_ev) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= HOLD_LOAD;
                    end else if (w_l1_ev) begin
                        r_score2 <= w_inc2;
                        if (w_p2_wins) begin
                            r_state     <= OVER;
                            r_winner    <= P2;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state    <= HOLD;
                            r_hold_cnt <= HOLD_LOAD;
                        end
                    end else if (w_l2_ev) begin
                        r_score1 <= w_inc1;
                        if (w_p1_wins) begin
                            r_state     <= OVER;
                            r_winner    <= P1;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state    <= HOLD;
                            r_hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    // Lose events are dropped for the whole hold-off.
                    if (r_hold_cnt == '0) begin
                        r_state <= PLAY;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HW'(1);
                    end
                end
                OVER: ;
            endcase
        end
    end

    assign score1    = r_score1;
    assign score2    = r_score2;
    assign playing   = r_playing;
    assign game_over = r_game_over;
    assign winner    = r_winner;

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg7_scan (
        .clk      (clk),
        .rst      (rst),
        .i_score1 (r_score1),
        .i_score2 (r_score2),
        .o_an     (an),
        .o_seg    (seg)
    );

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed self-checking bench for pong_score_keeper.
// u_dut  : WIN_SCORE=3, HOLD_CYCLES=4, SCAN_DIV=2 (match flow, hold, reset)
// u_scan : WIN_SCORE=20 so the display can be checked at 12 / 07
module tb_pong_score_keeper;
    import pong_score_keeper_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       lose1 = 1'b0;
    logic       lose2 = 1'b0;
    logic [7:0] score1;
    logic [7:0] score2;
    logic       playing;
    logic       game_over;
    logic       winner;
    logic [3:0] an;
    logic [6:0] seg;

    logic       start_b = 1'b0;
    logic       lose1_b = 1'b0;
    logic       lose2_b = 1'b0;
    logic [7:0] score1_b;
    logic [7:0] score2_b;
    logic       playing_b;
    logic       game_over_b;
    logic       winner_b;
    logic [3:0] an_b;
    logic [6:0] seg_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pong_score_keeper #(
        .WIN_SCORE   (3),
        .HOLD_CYCLES (4),
        .SCAN_DIV    (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lose1     (lose1),
        .lose2     (lose2),
        .score1    (score1),
        .score2    (score2),
        .playing   (playing),
        .game_over (game_over),
        .winner    (winner),
        .an        (an),
        .seg       (seg)
    );

    pong_score_keeper #(
        .WIN_SCORE   (20),
        .HOLD_CYCLES (4),
        .SCAN_DIV    (2)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .lose1     (lose1_b),
        .lose2     (lose2_b),
        .score1    (score1_b),
        .score2    (score2_b),
        .playing   (playing_b),
        .game_over (game_over_b),
        .winner    (winner_b),
        .an        (an_b),
        .seg       (seg_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Player point on u_dut: input high 2 cycles; 10 cycles total so the
    // following hold-off has ended.
    task automatic point(input logic l1, input logic l2);
        lose1 = l1;
        lose2 = l2;
        tick(2);
        lose1 = 1'b0;
        lose2 = 1'b0;
        tick(8);
    endtask

    logic [7:0] exp_s2 [3];
    logic       exp_go [3];
    logic [3:0] seen;
    logic [3:0] prev_an;
    logic [6:0] exp_seg;
    logic       an_ok;

    initial begin
        exp_s2 = '{8'h02, 8'h03, 8'h03};
        exp_go = '{1'b0, 1'b1, 1'b1};

        // Reset values
        tick(2);
        check_eq("rst_score1", 32'(score1), 32'h00);
        check_eq("rst_score2", 32'(score2), 32'h00);
        check_eq("rst_playing", 32'(playing), 32'h0);
        check_eq("rst_game_over", 32'(game_over), 32'h0);
        check_eq("rst_winner", 32'(winner), 32'h0);
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        rst = 1'b1;
        tick(2);

        // Start: playing rises exactly 4 cycles after the input rises
        start = 1'b1;
        tick(3);
        check_eq("start_lat3_playing", 32'(playing), 32'h0);
        tick(1);
        check_eq("start_playing", 32'(playing), 32'h1);
        check_eq("start_score1", 32'(score1), 32'h00);
        check_eq("start_score2", 32'(score2), 32'h00);
        check_eq("start_state", 32'(u_dut.r_state), 32'(PLAY));
        start = 1'b0;
        tick(6);

        // lose2 held high: one point 4 cycles after the rise, 4-cycle HOLD
        lose2 = 1'b1;
        tick(3);
        check_eq("l2_lat3_score1", 32'(score1), 32'h00);
        tick(1);
        check_eq("l2_score1", 32'(score1), 32'h01);
        check_eq("l2_hold_t4", 32'(u_dut.r_state), 32'(HOLD));
        // lose1 pulse whose event lands on the last HOLD cycle
        lose1 = 1'b1;
        tick(1);
        lose1 = 1'b0;
        check_eq("l2_hold_t5", 32'(u_dut.r_state), 32'(HOLD));
        tick(2);
        check_eq("l2_hold_t7", 32'(u_dut.r_state), 32'(HOLD));
        tick(1);
        check_eq("l2_play_t8", 32'(u_dut.r_state), 32'(PLAY));
        tick(4);
        check_eq("hold_l1_ignored", 32'(score2), 32'h00);
        tick(38);
        check_eq("l2_held_single", 32'(score1), 32'h01);
        lose2 = 1'b0;
        tick(2);

        // lose1 after HOLD scores for player 2
        lose1 = 1'b1;
        tick(3);
        check_eq("l1_lat3_score2", 32'(score2), 32'h00);
        tick(1);
        check_eq("l1_score2", 32'(score2), 32'h01);
        lose1 = 1'b0;
        tick(6);

        // Simultaneous misses: no score change, HOLD entered
        lose1 = 1'b1;
        lose2 = 1'b1;
        tick(4);
        check_eq("both_score1", 32'(score1), 32'h01);
        check_eq("both_score2", 32'(score2), 32'h01);
        check_eq("both_state", 32'(u_dut.r_state), 32'(HOLD));
        lose1 = 1'b0;
        lose2 = 1'b0;
        tick(6);

        // Three lose1 events 10 cycles apart: player 2 wins at 3
        for (int k = 0; k < 3; k++) begin
            lose1 = 1'b1;
            tick(2);
            lose1 = 1'b0;
            tick(2);
            check_eq("win_seq_score2", 32'(score2), 32'(exp_s2[k]));
            check_eq("win_seq_game_over", 32'(game_over), 32'(exp_go[k]));
            tick(6);
        end
        check_eq("win_winner", 32'(winner), 32'h1);
        check_eq("win_playing", 32'(playing), 32'h0);
        lose2 = 1'b1;
        tick(2);
        lose2 = 1'b0;
        tick(2);
        check_eq("over_l2_ignored", 32'(score1), 32'h01);
        check_eq("over_still_over", 32'(game_over), 32'h1);
        tick(6);

        // Restart from OVER
        start = 1'b1;
        tick(4);
        check_eq("restart_score1", 32'(score1), 32'h00);
        check_eq("restart_score2", 32'(score2), 32'h00);
        check_eq("restart_playing", 32'(playing), 32'h1);
        check_eq("restart_game_over", 32'(game_over), 32'h0);
        check_eq("restart_winner", 32'(winner), 32'h0);
        start = 1'b0;
        tick(6);

`ifdef PONG_DEUCE_EN
        for (int k = 0; k < 3; k++) begin
            point(1'b0, 1'b1);
            point(1'b1, 1'b0);
        end
        check_eq("deuce_33_score1", 32'(score1), 32'h03);
        check_eq("deuce_33_score2", 32'(score2), 32'h03);
        check_eq("deuce_33_over", 32'(game_over), 32'h0);
        point(1'b0, 1'b1);
        check_eq("deuce_43_score1", 32'(score1), 32'h04);
        check_eq("deuce_43_over", 32'(game_over), 32'h0);
        point(1'b0, 1'b1);
        check_eq("deuce_53_score1", 32'(score1), 32'h05);
        check_eq("deuce_53_over", 32'(game_over), 32'h1);
        check_eq("deuce_53_winner", 32'(winner), 32'h0);
        start = 1'b1;
        tick(4);
        start = 1'b0;
        tick(6);
`endif

        // Reset asserted mid-HOLD clears every output at once
        lose2 = 1'b1;
        tick(2);
        lose2 = 1'b0;
        tick(3);
        check_eq("pre_rst_hold", 32'(u_dut.r_state), 32'(HOLD));
        check_eq("pre_rst_score1", 32'(score1), 32'h01);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_score1", 32'(score1), 32'h00);
        check_eq("mid_rst_playing", 32'(playing), 32'h0);
        check_eq("mid_rst_game_over", 32'(game_over), 32'h0);
        check_eq("mid_rst_winner", 32'(winner), 32'h0);
        check_eq("mid_rst_an", 32'(an), 32'hF);
        check_eq("mid_rst_seg", 32'(seg), 32'h7F);
        check_eq("mid_rst_state", 32'(u_dut.r_state), 32'(IDLE));
        tick(2);
        rst = 1'b1;
        tick(2);

        // Build 12 / 07 on the scan instance, then watch the display
        start_b = 1'b1;
        tick(4);
        start_b = 1'b0;
        tick(6);
        for (int k = 0; k < 12; k++) begin
            lose2_b = 1'b1;
            tick(2);
            lose2_b = 1'b0;
            tick(8);
        end
        for (int k = 0; k < 7; k++) begin
            lose1_b = 1'b1;
            tick(2);
            lose1_b = 1'b0;
            tick(8);
        end
        check_eq("scan_score1", 32'(score1_b), 32'h12);
        check_eq("scan_score2", 32'(score2_b), 32'h07);
        tick(8);
        seen    = 4'b0000;
        prev_an = an_b;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            an_ok   = 1'b1;
            exp_seg = 7'h7F;
            case (an_b)
                4'b0111: begin exp_seg = 7'h79; seen[3] = 1'b1; end
                4'b1011: begin exp_seg = 7'h24; seen[2] = 1'b1; end
                4'b1101: begin exp_seg = 7'h7F; seen[1] = 1'b1; end
                4'b1110: begin exp_seg = 7'h78; seen[0] = 1'b1; end
                default: an_ok = 1'b0;
            endcase
            check_eq("scan_an_onehot", 32'(an_ok), 32'h1);
            check_eq("scan_seg", 32'(seg_b), 32'(exp_seg));
            if (an_b != prev_an) begin
                check_eq("scan_order", 32'(an_b), 32'({prev_an[0], prev_an[3:1]}));
            end
            prev_an = an_b;
        end
        check_eq("scan_all_digits", 32'(seen), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
